cpu_fpu_compare: RTL

Parametrised, IEEE-754-correct floating-point compare, min/max and classify unit. It replaces the subtract-based compare and min/max paths in the FPU dispatcher with a dedicated sign-magnitude datapath. Additions over those paths:
- NaN-correct semantics and exception flags.
- `fclass` support.
- Configurable format width.
- Configurable pipeline depth.

It sits beside the add/mul/div units under the FPU dispatcher and uses the same level-held request/ready handshake.

---
 rtl/cpu_fpu_compare.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_fpu_compare.sv
// rtl/cpu_fpu_compare.sv - IEEE-754 compare, min/max and classify unit
//
// Purpose: sign-magnitude floating-point compare (feq/flt/fle), min/max and
// fclass, with a request/ready handshake and a configurable result pipeline.
//
// Ports:
//   i_clock    - clock, rising edge
//   i_reset    - synchronous active-high reset
//   i_request  - level-held operation request
//   i_op       - operation code (OP_* parameters)
//   i_op1      - operand a
//   i_op2      - operand b (unused by CLASS)
//   o_ready    - result valid, high for one cycle while i_request is high
//   o_result   - registered result
//   o_flags    - registered fflags {NV,DZ,OF,UF,NX}
module cpu_fpu_compare #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    parameter int STAGES    = 1,
    parameter logic [4:0] OP_CMP_EQUAL  = 5'd10,
    parameter logic [4:0] OP_CMP_LESS   = 5'd11,
    parameter logic [4:0] OP_CMP_LEQUAL = 5'd12,
    parameter logic [4:0] OP_MIN        = 5'd13,
    parameter logic [4:0] OP_MAX        = 5'd14,
    parameter logic [4:0] OP_CLASS      = 5'd15,
    localparam int WIDTH = 1 + EXP_WIDTH + MAN_WIDTH
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_request,
    input  logic [4:0]       i_op,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [4:0]       o_flags
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WIDTH-1:0] CANON_NAN =
        {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_WIDTH-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [1:0]       count_q, count_d;
    logic [4:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       flags_q, flags_d;
    logic             capture;

    // ------------------------------------------------------------------
    // Operand classification
    // ------------------------------------------------------------------
    logic                 a_s, b_s;
    logic [EXP_WIDTH-1:0] a_e, b_e;
    logic [MAN_WIDTH-1:0] a_m, b_m;
    logic a_zero, a_sub, a_inf, a_nan, a_snan, a_qnan, a_norm;
    logic b_zero, b_nan, b_snan;

    assign {a_s, a_e, a_m} = a_q;
    assign {b_s, b_e, b_m} = b_q;

    assign a_zero = (a_e == '0) && (a_m == '0);
    assign a_sub  = (a_e == '0) && (a_m != '0);
    assign a_inf  = (&a_e) && (a_m == '0);
    assign a_nan  = (&a_e) && (a_m != '0);
    assign a_qnan = a_nan && a_m[MAN_WIDTH-1];
    assign a_snan = a_nan && !a_m[MAN_WIDTH-1];
    assign a_norm = (a_e != '0) && !(&a_e);

    assign b_zero = (b_e == '0) && (b_m == '0);
    assign b_nan  = (&b_e) && (b_m != '0);
    assign b_snan = b_nan && !b_m[MAN_WIDTH-1];

    logic any_nan, any_snan, both_zero;
    logic mag_lt, mag_gt;
    logic cmp_eq, cmp_lt, mm_lt;

    assign any_nan   = a_nan || b_nan;
    assign any_snan  = a_snan || b_snan;
    assign both_zero = a_zero && b_zero;
    assign mag_lt    = a_q[WIDTH-2:0] < b_q[WIDTH-2:0];
    assign mag_gt    = a_q[WIDTH-2:0] > b_q[WIDTH-2:0];

    // Compare ordering: +0 and -0 are equal.
    assign cmp_eq = (a_q == b_q) || both_zero;
    assign cmp_lt = (a_s != b_s) ? (a_s && !both_zero)
                                 : (a_s ? mag_gt : mag_lt);
    // Min/max ordering: -0 sorts below +0, so only the sign decides.
    assign mm_lt  = (a_s != b_s) ? a_s : (a_s ? mag_gt : mag_lt);

    logic [9:0] cls;
    assign cls = {a_qnan, a_snan,
                  !a_s && a_inf, !a_s && a_norm, !a_s && a_sub, !a_s && a_zero,
                  a_s && a_zero, a_s && a_sub, a_s && a_norm, a_s && a_inf};

    // ------------------------------------------------------------------
    // Combinational result from the latched operands: {nv, result}
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] comb_res;
    logic             comb_nv;
    logic [WIDTH:0]   comb_w, tail_w;

    always_comb begin
        comb_res = '0;
        comb_nv  = 1'b0;
        case (op_q)
            OP_CMP_EQUAL: begin
                comb_res = {{(WIDTH-1){1'b0}}, !any_nan && cmp_eq};
                comb_nv  = any_snan;
            end
            OP_CMP_LESS: begin
                comb_res = {{(WIDTH-1){1'b0}}, !any_nan && cmp_lt};
                comb_nv  = any_nan;
            end
            OP_CMP_LEQUAL: begin
                comb_res = {{(WIDTH-1){1'b0}}, !any_nan && (cmp_lt || cmp_eq)};
                comb_nv  = any_nan;
            end
            OP_MIN, OP_MAX: begin
                if (a_nan && b_nan)
                    comb_res = CANON_NAN;
                else if (a_nan)
                    comb_res = b_q;
                else if (b_nan)
                    comb_res = a_q;
                else if (op_q == OP_MIN)
                    comb_res = mm_lt ? a_q : b_q;
                else
                    comb_res = mm_lt ? b_q : a_q;
                comb_nv = any_snan;
            end
            OP_CLASS: begin
                comb_res = {{(WIDTH-10){1'b0}}, cls};
            end
            default: ;
        endcase
    end

    assign comb_w = {comb_nv, comb_res};

    // Operands are latched on the capture edge and the output register is
    // the last of the STAGES edges, so only STAGES-1 intermediate registers
    // sit between the combinational result and o_result.
    generate
        if (STAGES > 1) begin : g_pipe
            localparam int DEPTH = STAGES - 1;
            logic [WIDTH:0] pipe_q [DEPTH];
            always_ff @(posedge i_clock) begin
                if (i_reset) begin
                    for (int k = 0; k < DEPTH; k++) pipe_q[k] <= '0;
                end else begin
                    pipe_q[0] <= comb_w;
                    for (int k = 1; k < DEPTH; k++) pipe_q[k] <= pipe_q[k-1];
                end
            end
            assign tail_w = pipe_q[DEPTH-1];
        end else begin : g_direct
            assign tail_w = comb_w;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake state machine
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        result_d = result_q;
        flags_d  = flags_q;
        capture  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_request) begin
                    capture = 1'b1;
                    count_d = 2'(STAGES);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!i_request) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (count_q <= 2'd1) begin
                    // Final RUN cycle; STAGES=0 still spends one cycle here.
                    result_d = tail_w[WIDTH-1:0];
                    flags_d  = {tail_w[WIDTH], 4'b0000};
                    count_d  = '0;
                    state_d  = S_DONE;
                end else begin
                    count_d = count_q - 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            if (capture) begin
                op_q <= i_op;
                a_q  <= i_op1;
                b_q  <= i_op2;
            end
        end
    end

    assign o_ready  = (state_q == S_DONE) && i_request;
    assign o_result = result_q;
    assign o_flags  = flags_q;

endmodule
